// File: rtl/aes_ctr_step_if.sv
// Request/response handshake and counter slice port between the step FSM and its user.
interface aes_ctr_step_if #(
    parameter int SliceSize     = 16,
    parameter int StepWidth     = 8,
    parameter int SliceIdxWidth = 3
);
    logic                     incr;
    logic [StepWidth-1:0]     step;
    logic                     mode;
    logic                     ready;
    logic                     done;
    logic                     ovf;
    logic [SliceIdxWidth-1:0] ctr_slice_idx;
    logic [SliceSize-1:0]     ctr_slice_cur;
    logic [SliceSize-1:0]     ctr_slice_new;
    logic                     ctr_we;

    modport master (
        output incr, step, mode, ctr_slice_cur,
        input  ready, done, ovf, ctr_slice_idx, ctr_slice_new, ctr_we
    );

    modport slave (
        input  incr, step, mode, ctr_slice_cur,
        output ready, done, ovf, ctr_slice_idx, ctr_slice_new, ctr_we
    );
endinterface

// File: rtl/aes_ctr_step_fsm.sv
// Slice-serial counter increment for AES CTR (full-width wrap) and GCM inc32 (low 32-bit wrap).
module aes_ctr_step_fsm #(
    parameter int  CtrWidth      = 128,
    parameter int  SliceSize     = 16,
    parameter int  StepWidth     = 8,
    localparam int NumSlices     = CtrWidth / SliceSize,
    localparam int Num32         = 32 / SliceSize,
    localparam int SliceIdxWidth = $clog2(NumSlices)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    aes_ctr_step_if.slave    bus,
    input  logic             incr_err_i,
    input  logic             mr_err_i,
    output logic             alert_o
);
    localparam logic [SliceIdxWidth-1:0] LastFull = SliceIdxWidth'(NumSlices - 1);
    localparam logic [SliceIdxWidth-1:0] Last32   = SliceIdxWidth'(Num32 - 1);

    // Sparse encoding: any single flipped bit lands on an illegal code.
    typedef enum logic [5:0] {
        CTR_IDLE  = 6'b001110,
        CTR_INCR  = 6'b110101,
        CTR_ERROR = 6'b101000
    } ctr_state_e;

    ctr_state_e               state_q, state_d;
    logic [SliceIdxWidth-1:0] slice_idx_q, slice_idx_d;
    logic                     carry_q, carry_d;
    logic [StepWidth-1:0]     step_q, step_d;
    logic                     mode_q, mode_d;
    logic [SliceSize-1:0]     addend;
    logic [SliceSize:0]       sum;
    logic                     last;

    function automatic logic [SliceSize:0] add_slice(input logic [SliceSize-1:0] a,
                                                     input logic [SliceSize-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign addend = (slice_idx_q == '0) ? SliceSize'(step_q) : SliceSize'(carry_q);
    assign sum    = add_slice(bus.ctr_slice_cur, addend);
    assign last   = mode_q ? (slice_idx_q == Last32) : (slice_idx_q == LastFull);

    assign bus.ctr_slice_idx = slice_idx_q;

    always_comb begin
        state_d           = state_q;
        slice_idx_d       = slice_idx_q;
        carry_d           = carry_q;
        step_d            = step_q;
        mode_d            = mode_q;
        bus.ready         = 1'b0;
        bus.done          = 1'b0;
        bus.ovf           = 1'b0;
        bus.ctr_we        = 1'b0;
        bus.ctr_slice_new = '0;
        alert_o           = 1'b0;

        unique case (state_q)
            CTR_IDLE: begin
                bus.ready = 1'b1;
                if (bus.incr) begin
                    step_d      = bus.step;
                    mode_d      = bus.mode;
                    slice_idx_d = '0;
                    carry_d     = 1'b0;
                    state_d     = CTR_INCR;
                end
            end
            CTR_INCR: begin
                bus.ctr_we        = 1'b1;
                bus.ctr_slice_new = sum[SliceSize-1:0];
                carry_d           = sum[SliceSize];
                slice_idx_d       = slice_idx_q + 1'b1;
                if (last) begin
                    bus.done    = 1'b1;
                    bus.ovf     = sum[SliceSize];
                    slice_idx_d = '0;
                    state_d     = CTR_IDLE;
                end
            end
            CTR_ERROR: begin
                alert_o = 1'b1;
            end
            default: begin
                alert_o = 1'b1;
                state_d = CTR_ERROR;
            end
        endcase

        // Errors override every transition, even the final write cycle.
        if (incr_err_i || mr_err_i) begin
            state_d = CTR_ERROR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CTR_IDLE;
            slice_idx_q <= '0;
            carry_q     <= 1'b0;
            step_q      <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slice_idx_q <= slice_idx_d;
            carry_q     <= carry_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
        end
    end
endmodule

// File: tb/tb_aes_ctr_step_fsm.sv
// Randomised scoreboard bench for aes_ctr_step_fsm with an external 128-bit counter register.
module tb_aes_ctr_step_fsm;
    logic clk = 1'b0;
    logic rst_ni;
    logic incr_err;
    logic mr_err;
    logic alert;

    always #5 clk = ~clk;

    aes_ctr_step_if #(.SliceSize(16), .StepWidth(8), .SliceIdxWidth(3)) bus ();

    aes_ctr_step_fsm #(.CtrWidth(128), .SliceSize(16), .StepWidth(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .incr_err_i (incr_err),
        .mr_err_i   (mr_err),
        .alert_o    (alert)
    );

    logic [127:0] mem;
    logic [127:0] load_val;
    logic         load_en;
    int           cyc = 0;

    assign bus.ctr_slice_cur = mem[bus.ctr_slice_idx*16 +: 16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_en) mem <= load_val;
        else if (bus.ctr_we) mem[bus.ctr_slice_idx*16 +: 16] <= bus.ctr_slice_new;
    end

    typedef struct {
        logic [127:0] ctr;
        logic         ovf;
        int           done_cyc;
        int           k;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    int   wr_cnt = 0;
    logic mem_chk = 1'b0;
    logic [127:0] chk_ctr;
    always @(negedge clk) begin
        if (!rst_ni) begin
            wr_cnt  = 0;
            mem_chk = 1'b0;
        end else begin
            if (mem_chk) begin
                check("ctr_value", mem, chk_ctr);
                check("ready_after_done", 128'(bus.ready), 128'(1));
                mem_chk = 1'b0;
            end
            if (bus.ctr_we) begin
                check("slice_idx", 128'(bus.ctr_slice_idx), 128'(wr_cnt));
                wr_cnt++;
            end else begin
                wr_cnt = 0;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 128'(1), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ovf", 128'(bus.ovf), 128'(e.ovf));
                    check("write_count", 128'(wr_cnt), 128'(e.k));
                    check("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    chk_ctr = e.ctr;
                    mem_chk = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (bus.ready) return;
            @(negedge clk);
        end
        check("ready_timeout", 128'(bus.ready), 128'(1));
    endtask

    task automatic load(input logic [127:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Reference: plain big-integer arithmetic over the selected span.
    task automatic push_exp(input logic [127:0] init, input logic [7:0] step, input logic mode);
        exp_t e;
        logic [128:0] s;
        logic [32:0]  l;
        if (mode) begin
            l     = {1'b0, init[31:0]} + 33'(step);
            e.ctr = {init[127:32], l[31:0]};
            e.ovf = l[32];
            e.k   = 2;
        end else begin
            s     = {1'b0, init} + 129'(step);
            e.ctr = s[127:0];
            e.ovf = s[128];
            e.k   = 8;
        end
        e.done_cyc = cyc + e.k;
        sb.push_back(e);
    endtask

    task automatic start(input logic [127:0] init, input logic [7:0] step, input logic mode,
                         input bit track);
        wait_ready();
        load(init);
        if (track) push_exp(init, step, mode);
        bus.incr = 1'b1;
        bus.step = step;
        bus.mode = mode;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [127:0] init, input logic [7:0] step, input logic mode,
                          input bit hold);
        start(init, step, mode, 1'b1);
        if (hold) begin
            for (int i = 0; i < 20; i++) begin
                if (bus.done) break;
                @(negedge clk);
            end
        end
        bus.incr = 1'b0;
    endtask

    task automatic wait_idx(input int idx);
        for (int i = 0; i < 20; i++) begin
            if (bus.ctr_we && bus.ctr_slice_idx == 3'(idx)) return;
            @(negedge clk);
        end
        check("idx_wait_timeout", 128'(bus.ctr_slice_idx), 128'(idx));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        incr_err = 1'b0;
        mr_err = 1'b0;
        bus.incr = 1'b0;
        bus.step = '0;
        bus.mode = 1'b0;
        load_en = 1'b0;
        load_val = '0;
        mem = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(bus.ready), 128'(1));
        check("rst_outputs", 128'({bus.done, bus.ovf, bus.ctr_we, alert}), 128'(0));
        check("rst_idx_slice", 128'({bus.ctr_slice_idx, bus.ctr_slice_new}), 128'(0));
        rst_ni = 1'b1;
        @(negedge clk);

        run_op(128'h00FF_FFFF, 8'd1, 1'b0, 1'b0);
        run_op({128{1'b1}}, 8'd1, 1'b0, 1'b0);
        run_op({96'h1111_1111_1111_1111_1111_1111, 32'hFFFF_FFFF}, 8'd3, 1'b1, 1'b0);
        run_op(128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 8'd0, 1'b0, 1'b1);
        wait_ready();
        repeat (2) begin
            @(negedge clk);
            check("no_restart_we", 128'(bus.ctr_we), 128'(0));
        end
        check("const_wrap_low", mem, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);

        for (int n = 0; n < 25; n++) begin
            logic [127:0] v;
            v = {$urandom, $urandom, $urandom, $urandom};
            if (n % 5 == 0) v[63:0] = {64{1'b1}};
            run_op(v, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_ready();
        @(negedge clk);

        // Sibling error mid-operation locks the FSM.
        start(128'h0, 8'd1, 1'b0, 1'b0);
        bus.incr = 1'b0;
        wait_idx(3);
        mr_err = 1'b1;
        @(negedge clk);
        mr_err = 1'b0;
        check("err_alert", 128'(alert), 128'(1));
        check("err_quiet", 128'({bus.ctr_we, bus.ready, bus.done}), 128'(0));
        bus.incr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("err_locked", 128'({alert, bus.ready, bus.ctr_we}), 128'(3'b100));
        end
        bus.incr = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Reset in the middle of an operation.
        start(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 8'd9, 1'b0, 1'b0);
        bus.incr = 1'b0;
        wait_idx(5);
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", 128'(bus.ready), 128'(1));
        check("midrst_outs", 128'({bus.ctr_we, bus.done, bus.ovf, alert, bus.ctr_slice_idx}), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFF0, 8'd32, 1'b0, 1'b0);
        wait_ready();
        @(negedge clk);

        incr_err = 1'b1;
        @(negedge clk);
        incr_err = 1'b0;
        check("incr_err_alert", 128'({alert, bus.ready}), 128'(2'b10));
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
